i2s_tx_controller: RTL

I2S_TX_CONTROLLER -- requirements
Module: i2s_tx_controller

---
 rtl/i2s_tx_controller.sv | 127 ++++++++++++
 1 files changed

// File: rtl/i2s_tx_controller.sv
`default_nettype none
// ============================================================================
// i2s_tx_controller : 16-bit stereo I2S transmitter, 64-bit frame (2 x 32 slots)
//   Optional fallback tone on underrun: define I2S_TONE_GEN_EN
// Revision: 1.0
// ============================================================================
module i2s_tx_controller #(
   parameter int CLK_DIV   = 4,
   parameter int TONE_HALF = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [15:0] sample_left,
   input  logic [15:0] sample_right,
   output logic        sample_ready,
   input  logic        underrun_clr,
   output logic        bck,
   output logic        lrck,
   output logic        data,
   output logic        frame_start,
   output logic        underrun
);
   if (CLK_DIV < 1 || CLK_DIV > 255 || TONE_HALF < 1) begin : g_param_check
      $error("i2s_tx_controller: CLK_DIV must be 1..255 and TONE_HALF >= 1");
   end

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0]  div_q;
   logic        bck_q, lrck_q, data_q, frame_start_q, underrun_q, hold_full_q;
   logic [5:0]  bit_cnt_q;
   logic [5:0]  bit_cnt_d;
   logic [15:0] hold_l_q, hold_r_q, shift_l_q, shift_r_q;
   logic [15:0] fallback;
   logic        tick, fall, load, xfer, in_word;

   assign tick         = (div_q == DIV_LAST);
   assign fall         = tick && bck_q;
   assign load         = fall && (bit_cnt_q == 6'd63);
   assign sample_ready = !hold_full_q && !rst;
   assign xfer         = sample_valid && sample_ready;
   assign bit_cnt_d    = bit_cnt_q + 6'd1;
   // Slot bit 0 is the one-bck I2S delay after lrck changes; bits 1..16 carry the word.
   assign in_word      = (bit_cnt_d[4:0] != 5'd0) && (bit_cnt_d[4:0] <= 5'd16);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q         <= '0;
         bck_q         <= 1'b0;
         lrck_q        <= 1'b0;
         data_q        <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         hold_full_q   <= 1'b0;
         bit_cnt_q     <= 6'd63;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         shift_l_q     <= '0;
         shift_r_q     <= '0;
      end else begin
         frame_start_q <= load;
         if (tick) begin
            div_q <= '0;
            bck_q <= !bck_q;
         end else begin
            div_q <= div_q + 8'd1;
         end
         if (fall) begin
            bit_cnt_q <= bit_cnt_d;
            lrck_q    <= bit_cnt_d[5];
            data_q    <= in_word && (bit_cnt_d[5] ? shift_r_q[15] : shift_l_q[15]);
            if (in_word && !bit_cnt_d[5]) shift_l_q <= {shift_l_q[14:0], 1'b0};
            if (in_word && bit_cnt_d[5])  shift_r_q <= {shift_r_q[14:0], 1'b0};
         end
         if (load) begin
            shift_l_q <= hold_full_q ? hold_l_q : fallback;
            shift_r_q <= hold_full_q ? hold_r_q : fallback;
         end
         // A transfer can only coincide with a load when the holder is empty, so it refills it.
         if (xfer) begin
            hold_full_q <= 1'b1;
            hold_l_q    <= sample_left;
            hold_r_q    <= sample_right;
         end else if (load) begin
            hold_full_q <= 1'b0;
         end
         if (load && !hold_full_q) underrun_q <= 1'b1;
         else if (underrun_clr)    underrun_q <= 1'b0;
      end
   end

`ifdef I2S_TONE_GEN_EN
   localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

   logic [TONE_W-1:0] tone_cnt_q;
   logic              tone_hi_q;

   // Tone phase advances every frame whatever the source, keeping the square wave periodic.
   always_ff @(posedge clk) begin
      if (rst) begin
         tone_cnt_q <= '0;
         tone_hi_q  <= 1'b0;
      end else if (load) begin
         if (tone_cnt_q == TONE_LAST) begin
            tone_cnt_q <= '0;
            tone_hi_q  <= !tone_hi_q;
         end else begin
            tone_cnt_q <= tone_cnt_q + TONE_W'(1);
         end
      end
   end

   assign fallback = tone_hi_q ? 16'h8001 : 16'h7FF5;
`else
   assign fallback = 16'h0000;
`endif

   assign bck         = bck_q;
   assign lrck        = lrck_q;
   assign data        = data_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

endmodule
`default_nettype wire
